// File: rtl/data_memory_if.sv
// Load/store request and response bundle between the MEM stage and data_memory.
// master: MEM stage drives req_*; slave: memory drives resp_*.
interface data_memory_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_err_code;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  resp_valid, resp_rdata,
    input  resp_err, resp_err_code
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output resp_valid, resp_rdata,
    output resp_err, resp_err_code
  );
endinterface

// File: rtl/data_memory.sv
// RV32 byte-addressed little-endian data memory, B/H/W access, 1-cycle response.
// Ports: clk, rst_n (sync, active-low), bus (data_memory_if.slave).
// Option: DMEM_BOUNDS_CHECK_EN enables out-of-range detection (code 10).
module data_memory #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  data_memory_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [2:0]    f3;
  logic          oor;

  assign lane = bus.req_addr[1:0];
  assign f3   = bus.req_funct3;

`ifdef DMEM_BOUNDS_CHECK_EN
  // Bit 32 of the widened difference is the borrow, i.e. addr < BASE.
  logic [32:0] diff;
  assign diff = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign idx  = diff[AW+1:2];
  assign oor  = diff[32] | (|diff[31:AW+2]);
`else
  // Upper offset bits are dropped, so accesses alias modulo the array.
  logic [31:0] off;
  logic        unused_hi;
  assign off       = bus.req_addr - BASE_ADDR;
  assign idx       = off[AW+1:2];
  assign unused_hi = ^{off[31:AW+2], off[1:0]};
  assign oor       = 1'b0;
`endif

  logic is_b, is_h, is_w, uns;
  logic illegal, mis, err;
  logic [1:0] code;

  assign is_b    = f3[1:0] == 2'b00;
  assign is_h    = f3[1:0] == 2'b01;
  assign is_w    = f3[1:0] == 2'b10;
  assign uns     = f3[2];
  assign illegal = (f3[1:0] == 2'b11) | (f3[2:1] == 2'b11);
  assign mis     = (is_h & lane[0]) | (is_w & (|lane));

  always_comb begin
    code = 2'b00;
    priority case (1'b1)
      illegal: code = 2'b11;
      oor:     code = 2'b10;
      mis:     code = 2'b01;
      default: code = 2'b00;
    endcase
  end

  assign err = |code;

  logic        acc;
  logic        wr_en;
  logic [3:0]  be;
  logic [31:0] wd;

  assign acc   = rst_n & bus.req_valid;
  assign wr_en = acc & bus.req_we & ~err;

  // Store data is replicated across lanes; byte enables pick the target.
  always_comb begin
    be = 4'b0000;
    wd = bus.req_wdata;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << lane;
        wd = {4{bus.req_wdata[7:0]}};
      end
      is_h: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      is_w: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  logic [31:0] word;
  logic [31:0] sh;
  logic [31:0] ld;

  assign word = mem[idx];
  assign sh   = word >> {lane, 3'b000};

  always_comb begin
    ld = word;
    unique case (1'b1)
      is_b: ld = uns ? {24'h0, sh[7:0]}
                     : {{24{sh[7]}}, sh[7:0]};
      is_h: ld = uns ? {16'h0, sh[15:0]}
                     : {{16{sh[15]}}, sh[15:0]};
      default: ld = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= 32'h0;
      bus.resp_err      <= 1'b0;
      bus.resp_err_code <= 2'b00;
    end else begin
      bus.resp_valid    <= bus.req_valid;
      bus.resp_err      <= bus.req_valid & err;
      bus.resp_err_code <= bus.req_valid ? code : 2'b00;
      if (bus.req_valid && !bus.req_we && !err)
        bus.resp_rdata <= ld;
      else
        bus.resp_rdata <= 32'h0;
    end
  end

endmodule
